// File: rtl/tqvp_prism_pkg.sv
// Shared definitions for the PRISM loader: state encoding,
// default parameters and the packed load-word layout.
package tqvp_prism_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam int DEF_DEPTH      = 4;
    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 255;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int WORD_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ld_word_t;

endpackage

// File: rtl/tqvp_prism_loader_fifo.sv
// Load FIFO for the PRISM loader (DEPTH words, power of 2).
// Ports: clk/rst, push+wdata, pop->rdata, flush, full, empty.
module tqvp_prism_loader_fifo
    import tqvp_prism_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tqvp_prism_loader.sv
// PRISM loader: resets PRISM, streams FIFO words into its debug
// port, then runs it. Host debug writes share the port outside
// RESET/LOAD. Outputs: p_* debug bus, state, done/halt_irq, err/ovf.
module tqvp_prism_loader
    import tqvp_prism_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  host_addr,
    input  logic [31:0] host_wdata,
    input  logic        host_wr,
    output logic        host_busy,
    input  logic        ld_push,
    input  logic [5:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_full,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  word_cnt,
    input  logic        p_halt,
    output logic        p_reset,
    output logic        p_enable,
    output logic [5:0]  p_addr,
    output logic [31:0] p_wdata,
    output logic        p_wr,
    output logic [2:0]  state,
    output logic        done,
    output logic        halt_irq,
    output logic        err,
    output logic        ovf
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t      st;
    state_t      next;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] to_cnt;
    logic [4:0]  rem;
    logic        p_halt_q;
    logic        pop;
    logic        flush;
    logic        start_acc;
    logic        host_acc;
    logic        fifo_empty;
    logic        fifo_full;
    ld_word_t    wr_word;
    ld_word_t    rd_word;

    assign wr_word = '{addr: ld_addr, data: ld_data};

    tqvp_prism_loader_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_push),
        .wdata (wr_word),
        .pop   (pop),
        .flush (flush),
        .rdata (rd_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ld_full   = fifo_full;
    assign state     = st;
    assign host_busy = (st == S_RESET) || (st == S_LOAD);
    assign host_acc  = host_wr & ~host_busy;
    assign p_reset   = (st == S_RESET) || (st == S_LOAD) ||
                       (st == S_ERROR);
    assign p_enable  = (st == S_RUN) || (st == S_HALTED);

    always_comb begin
        next      = st;
        pop       = 1'b0;
        start_acc = 1'b0;
        case (st)
            S_IDLE: begin
                if (start) begin
                    next      = S_RESET;
                    start_acc = 1'b1;
                end
            end
            S_RESET: begin
                if (rst_cnt == RW'(RST_CYCLES - 1))
                    next = (rem == 5'd0) ? S_RUN : S_LOAD;
            end
            S_LOAD: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (rem == 5'd1) next = S_RUN;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    next = S_ERROR;
                end
            end
            S_RUN: begin
                if (start) begin
                    next      = S_RESET;
                    start_acc = 1'b1;
                end else if (p_halt && !p_halt_q) begin
                    next = S_HALTED;
                end
            end
            S_HALTED: begin
                if (start) begin
                    next      = S_RESET;
                    start_acc = 1'b1;
                end else if (!p_halt) begin
                    next = S_RUN;
                end
            end
            S_ERROR: begin
                if (start) begin
                    next      = S_RESET;
                    start_acc = 1'b1;
                end
            end
            default: next = S_IDLE;
        endcase
        if (abort) begin
            next      = S_IDLE;
            pop       = 1'b0;
            start_acc = 1'b0;
        end
    end

    // FIFO is emptied on abort and on the cycle that enters ERROR.
    assign flush = abort || ((st == S_LOAD) && (next == S_ERROR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IDLE;
        end else begin
            st <= next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt  <= '0;
            to_cnt   <= '0;
            rem      <= '0;
            p_halt_q <= 1'b0;
            p_addr   <= '0;
            p_wdata  <= '0;
            p_wr     <= 1'b0;
            done     <= 1'b0;
            halt_irq <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            p_halt_q <= p_halt;
            rst_cnt  <= (st == S_RESET && next == S_RESET) ?
                        rst_cnt + RW'(1) : '0;
            to_cnt   <= (st == S_LOAD && next == S_LOAD && fifo_empty) ?
                        to_cnt + TW'(1) : '0;
            if (start_acc)
                rem <= word_cnt;
            else if (pop)
                rem <= rem - 5'd1;
            // Loader owns the port in LOAD; host owns it elsewhere.
            p_wr <= pop | host_acc;
            if (pop) begin
                p_addr  <= rd_word.addr;
                p_wdata <= rd_word.data;
            end else if (host_acc) begin
                p_addr  <= host_addr;
                p_wdata <= host_wdata;
            end
            done     <= (next == S_RUN) &&
                        ((st == S_RESET) || (st == S_LOAD));
            halt_irq <= (st == S_RUN) && (next == S_HALTED);
            if (start_acc)
                err <= 1'b0;
            else if (next == S_ERROR && st != S_ERROR)
                err <= 1'b1;
            if (ld_push && fifo_full)
                ovf <= 1'b1;
            else if (start_acc)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tqvp_prism_loader.sv
// Scoreboard bench for tqvp_prism_loader: expected debug-port
// writes are queued by stimulus and popped by a p_wr monitor.
module tb_tqvp_prism_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_wr;
    logic        host_busy;
    logic        ld_push;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_full;
    logic        start;
    logic        abort;
    logic [4:0]  word_cnt;
    logic        p_halt;
    logic        p_reset;
    logic        p_enable;
    logic [5:0]  p_addr;
    logic [31:0] p_wdata;
    logic        p_wr;
    logic [2:0]  state;
    logic        done;
    logic        halt_irq;
    logic        err;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    logic [37:0] expq [$];

    tqvp_prism_loader dut (
        .clk        (clk),
        .rst        (rst),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_wr    (host_wr),
        .host_busy  (host_busy),
        .ld_push    (ld_push),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_full    (ld_full),
        .start      (start),
        .abort      (abort),
        .word_cnt   (word_cnt),
        .p_halt     (p_halt),
        .p_reset    (p_reset),
        .p_enable   (p_enable),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_wr       (p_wr),
        .state      (state),
        .done       (done),
        .halt_irq   (halt_irq),
        .err        (err),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every debug write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && p_wr) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL p_wr_unexp: got %0h/%0h expected none",
                         p_addr, p_wdata);
            end else begin
                logic [37:0] e;
                e = expq.pop_front();
                if ({p_addr, p_wdata} !== e) begin
                    errors++;
                    $display("FAIL p_wr_data: got %0h/%0h expected %0h/%0h",
                             p_addr, p_wdata, e[37:32], e[31:0]);
                end
            end
        end
    end

    task automatic push_word(input logic [5:0] a, input logic [31:0] d,
                             input bit expect_wr);
        ld_push = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (expect_wr) expq.push_back({a, d});
        step();
        ld_push = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        word_cnt = n;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max);
        int n;
        n = 0;
        while (state != s && n < max) begin
            step();
            n++;
        end
        chk("wait_state", {29'd0, state}, {29'd0, s});
    endtask

    // Fill probe: occupancy was zero iff full appears only on push 4.
    task automatic probe_empty(input string tag);
        for (int i = 0; i < 3; i++) push_word(6'h3F, 32'h0, 1'b0);
        chk({tag, "_not_full3"}, {31'd0, ld_full}, 32'd0);
        push_word(6'h3F, 32'h0, 1'b0);
        chk({tag, "_full4"}, {31'd0, ld_full}, 32'd1);
        do_abort();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        host_addr = '0; host_wdata = '0; host_wr = 1'b0;
        ld_push = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; abort = 1'b0; word_cnt = '0; p_halt = 1'b0;
        step();
        step();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_outs", {22'd0, p_reset, p_enable, p_wr, done,
            halt_irq, err, ovf, ld_full, host_busy, |p_addr},
            32'd0);
        rst = 1'b0;
        step();

        // Three-word load
        push_word(6'h04, 32'hA1, 1'b1);
        push_word(6'h08, 32'hB2, 1'b1);
        push_word(6'h0C, 32'hC3, 1'b1);
        pulse_start(5'd3);
        for (int i = 0; i < 4; i++) begin
            chk("reset_state", {29'd0, state}, 32'd1);
            chk("reset_prst", {30'd0, p_reset, p_enable}, 32'b10);
            chk("reset_busy", {31'd0, host_busy}, 32'd1);
            step();
        end
        chk("load_state", {29'd0, state}, 32'd2);
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        chk("done_latency", n, 32'd3);
        chk("run_state", {29'd0, state}, 32'd3);
        chk("run_en", {30'd0, p_reset, p_enable}, 32'b01);
        step();
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("q_drained1", expq.size(), 32'd0);

        // Host write in RUN
        chk("run_busy", {31'd0, host_busy}, 32'd0);
        host_wr = 1'b1; host_addr = 6'h2A; host_wdata = 32'hDEADBEEF;
        expq.push_back({6'h2A, 32'hDEADBEEF});
        step();
        host_wr = 1'b0;
        step();
        chk("q_drained2", expq.size(), 32'd0);

        // Halt edge
        p_halt = 1'b1;
        step();
        chk("halt_state", {29'd0, state}, 32'd4);
        chk("halt_irq1", {31'd0, halt_irq}, 32'd1);
        step();
        chk("halt_irq0", {31'd0, halt_irq}, 32'd0);
        chk("halt_en", {31'd0, p_enable}, 32'd1);
        p_halt = 1'b0;
        step();
        chk("unhalt_state", {29'd0, state}, 32'd3);
        chk("unhalt_done", {31'd0, done}, 32'd0);
        step();
        chk("unhalt_done2", {31'd0, done}, 32'd0);

        // Overflow
        for (int i = 0; i < 3; i++) push_word(6'h01, 32'h1, 1'b0);
        chk("ovf_nf3", {31'd0, ld_full}, 32'd0);
        push_word(6'h01, 32'h1, 1'b0);
        chk("ovf_full4", {31'd0, ld_full}, 32'd1);
        chk("ovf_0", {31'd0, ovf}, 32'd0);
        push_word(6'h01, 32'h1, 1'b0);
        chk("ovf_1", {31'd0, ovf}, 32'd1);
        chk("ovf_full5", {31'd0, ld_full}, 32'd1);
        do_abort();
        chk("abort_idle", {29'd0, state}, 32'd0);
        chk("abort_flush", {31'd0, ld_full}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Host blocked in LOAD, then abort+start
        push_word(6'h10, 32'h55, 1'b1);
        pulse_start(5'd2);
        chk("start_clr_ovf", {31'd0, ovf}, 32'd0);
        wait_state(3'd2, 20);
        host_wr = 1'b1; host_addr = 6'h11; host_wdata = 32'hBAD;
        chk("load_busy", {31'd0, host_busy}, 32'd1);
        step();
        host_wr = 1'b0;
        step();
        chk("q_drained3", expq.size(), 32'd0);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("as_state", {29'd0, state}, 32'd0);
        chk("as_outs", {30'd0, p_reset, p_enable}, 32'd0);
        probe_empty("as");

        // Timeout
        push_word(6'h20, 32'h77, 1'b1);
        pulse_start(5'd2);
        wait_state(3'd2, 20);
        n = 0;
        while (state == 3'd2 && n < 400) begin
            n++;
            step();
        end
        chk("load_cycles", n, 32'd256);
        chk("err_state", {29'd0, state}, 32'd5);
        chk("err_flag", {31'd0, err}, 32'd1);
        chk("err_outs", {30'd0, p_reset, p_enable}, 32'b10);
        chk("q_drained4", expq.size(), 32'd0);
        probe_empty("err");
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Async reset mid-LOAD
        push_word(6'h30, 32'h12345678, 1'b1);
        pulse_start(5'd2);
        wait_state(3'd2, 20);
        step();
        step();
        chk("pre_rst_addr", {26'd0, p_addr}, 32'h30);
        rst = 1'b1;
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_addr", {26'd0, p_addr}, 32'd0);
        chk("arst_data", p_wdata, 32'd0);
        chk("arst_outs", {23'd0, p_reset, p_enable, p_wr, done,
            halt_irq, err, ovf, ld_full, host_busy}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("q_final", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
